// File: rtl/vga_capture.sv
// Receive side of the VGA path: registers the sync/RGB pins, rebuilds the active-pixel
// stream with x/y coordinates, flags line/frame structure errors and sums each frame.
module vga_capture #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int H_BACK   = 160,
  parameter int V_BACK   = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vga_hsync,
  input  logic        i_vga_vsync,
  input  logic [4:0]  i_vga_red,
  input  logic [5:0]  i_vga_green,
  input  logic [4:0]  i_vga_blue,
  output logic        o_pix_valid,
  output logic [15:0] o_pix_data,
  output logic [10:0] o_pix_x,
  output logic [10:0] o_pix_y,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic [31:0] o_frame_sum,
  output logic [15:0] o_frame_cnt,
  output logic        o_line_err,
  output logic        o_frame_err
);

  localparam logic        HS_ACT   = HS_POL;
  localparam logic        VS_ACT   = VS_POL;
  localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [10:0] HB_LAST  = 11'(H_BACK - 1);
  localparam logic [10:0] LC_OPEN  = 11'(V_BACK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VBLANK,
    S_HBP,
    S_ACTIVE,
    S_HBLANK,
    S_WAIT_VS
  } state_t;

  logic        r_hs_s1, r_hs_s2, r_vs_s1, r_vs_s2;
  logic [15:0] r_rgb_s1;

  state_t      r_state;
  logic [10:0] r_lc, r_hcnt, r_x, r_y;
  logic        r_ok, r_done_pend;
  logic [31:0] r_acc;

  state_t      w_state_next;
  logic [10:0] w_lc_next, w_hcnt_next, w_x_next, w_y_next;
  logic        w_ok_next, w_emit, w_finish, w_open, w_line_err, w_frame_err;
  logic        w_hs_end, w_vs_end, w_first_pix;

  // Sync registers reset to the inactive level so releasing reset never looks like a sync end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hs_s1  <= ~HS_ACT;
      r_hs_s2  <= ~HS_ACT;
      r_vs_s1  <= ~VS_ACT;
      r_vs_s2  <= ~VS_ACT;
      r_rgb_s1 <= '0;
    end else begin
      r_hs_s1  <= i_vga_hsync;
      r_hs_s2  <= r_hs_s1;
      r_vs_s1  <= i_vga_vsync;
      r_vs_s2  <= r_vs_s1;
      r_rgb_s1 <= {i_vga_red, i_vga_green, i_vga_blue};
    end
  end

  assign w_hs_end    = (r_hs_s1 == ~HS_ACT) && (r_hs_s2 == HS_ACT);
  assign w_vs_end    = (r_vs_s1 == ~VS_ACT) && (r_vs_s2 == VS_ACT);
  assign w_first_pix = (r_x == 11'd0) && (r_y == 11'd0);

  always_comb begin
    w_state_next = r_state;
    w_lc_next    = r_lc;
    w_hcnt_next  = r_hcnt;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_ok_next    = r_ok;
    w_emit       = 1'b0;
    w_finish     = 1'b0;
    w_open       = 1'b0;
    w_line_err   = 1'b0;
    w_frame_err  = 1'b0;

    // A vsync end wins over any hsync end in the same cycle.
    if (w_vs_end) begin
      w_frame_err  = (r_state == S_VBLANK) || (r_state == S_HBP) ||
                     (r_state == S_ACTIVE) || (r_state == S_HBLANK);
      w_state_next = S_VBLANK;
      w_lc_next    = 11'd0;
      w_ok_next    = 1'b1;
    end else begin
      case (r_state)
        S_VBLANK: begin
          if (w_hs_end) begin
            if (r_lc == LC_OPEN) begin
              w_open   = 1'b1;
              w_y_next = 11'd0;
            end else begin
              w_lc_next = r_lc + 11'd1;
            end
          end
        end
        S_HBP: begin
          if (r_hcnt == HB_LAST) begin
            w_state_next = S_ACTIVE;
            w_x_next     = 11'd0;
          end else begin
            w_hcnt_next = r_hcnt + 11'd1;
          end
        end
        S_ACTIVE: begin
          // An hsync end mid-row abandons the row and opens the next one.
          if (w_hs_end) begin
            w_line_err = 1'b1;
            w_ok_next  = 1'b0;
            if (r_y == Y_LAST) begin
              w_finish = 1'b1;
            end else begin
              w_open   = 1'b1;
              w_y_next = r_y + 11'd1;
            end
          end else begin
            w_emit = 1'b1;
            if (r_x == X_LAST) begin
              if (r_y == Y_LAST) begin
                w_finish = 1'b1;
              end else begin
                w_state_next = S_HBLANK;
                w_y_next     = r_y + 11'd1;
              end
            end else begin
              w_x_next = r_x + 11'd1;
            end
          end
        end
        S_HBLANK: begin
          if (w_hs_end) begin
            w_open = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (w_open) begin
      if (H_BACK > 1) begin
        w_state_next = S_HBP;
        w_hcnt_next  = 11'd1;
      end else begin
        w_state_next = S_ACTIVE;
        w_x_next     = 11'd0;
      end
    end
    if (w_finish) begin
      w_state_next = S_WAIT_VS;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_lc        <= '0;
      r_hcnt      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_ok        <= 1'b0;
      r_done_pend <= 1'b0;
      r_acc       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_lc        <= w_lc_next;
      r_hcnt      <= w_hcnt_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_ok        <= w_ok_next;
      r_done_pend <= w_finish;
      if (w_emit) begin
        r_acc <= w_first_pix ? {16'd0, r_rgb_s1} : r_acc + {16'd0, r_rgb_s1};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pix_valid   <= 1'b0;
      o_pix_data    <= '0;
      o_pix_x       <= '0;
      o_pix_y       <= '0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_ok    <= 1'b0;
      o_frame_sum   <= '0;
      o_frame_cnt   <= '0;
      o_line_err    <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      o_pix_valid   <= w_emit;
      o_frame_start <= w_emit && w_first_pix;
      o_line_err    <= w_line_err;
      o_frame_err   <= w_frame_err;
      o_frame_done  <= r_done_pend;
      if (w_emit) begin
        o_pix_data <= r_rgb_s1;
        o_pix_x    <= r_x;
        o_pix_y    <= r_y;
      end
      // The last pixel was folded into r_acc on the previous edge.
      if (r_done_pend) begin
        o_frame_sum <= r_acc;
        o_frame_ok  <= r_ok;
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of `vga_ctrl`. It samples the VGA sync and RGB pins in the pixel clock domain and recovers the active-pixel stream with x/y coordinates. It checks line and frame structure and produces a per-frame pixel checksum. It sits on a loopback or test path, so the SDRAM/VGA display chain can be checked end to end against the pattern from `vga_data_gen`.

## Interface
Parameters:
- `H_ACTIVE`, 1024, active pixels per line
- `V_ACTIVE`, 768, active rows per frame
- `H_BACK`, 160, clocks from hsync end to pixel x=0
- `V_BACK`, 29, hsync-end events from vsync end to the event that opens row 0, minus one
- `HS_POL`, 0, active level of hsync
- `VS_POL`, 0, active level of vsync

Ports:
- `clk`  in  1  pixel clock, one pixel per cycle
- `rst`  in  1  asynchronous, active-high reset
- `vga_hsync`  in  1  horizontal sync
- `vga_vsync`  in  1  vertical sync
- `vga_red`  in  5  red
- `vga_green`  in  6  green
- `vga_blue`  in  5  blue
- `pix_valid`  out  1  active pixel on `pix_data`
- `pix_data`  out  16  pixel as {red, green, blue}
- `pix_x`  out  11  column of the current pixel
- `pix_y`  out  11  row of the current pixel
- `frame_start`  out  1  pulse coincident with pixel (0,0)
- `frame_done`  out  1  pulse one cycle after the last pixel of row V_ACTIVE-1
- `frame_ok`  out  1  valid with `frame_done`; 1 when the frame had no `line_err`
- `frame_sum`  out  32  sum of all `pix_data` values in the frame, mod 2^32; updated with `frame_done`
- `frame_cnt`  out  16  completed frames, wraps
- `line_err`  out  1  pulse: hsync end arrived during ACTIVE
- `frame_err`  out  1  pulse: vsync end arrived before the frame completed

## Operation
- **Reset.**
  - All outputs 0.
  - Input registers take the inactive sync levels, so no edge is seen after reset release.
  - State goes to IDLE.
- **Input stage.** All pins are registered into s1, and s1 is registered into s2 (syncs only).
  - hs_end: s1 hsync is inactive and s2 hsync is active. This is the cycle with offset 0.
  - vs_end is defined the same way on vsync.
- **States:**
  - IDLE: wait for vs_end, then go to VBLANK with line count lc=0.
  - VBLANK: each hs_end increments lc. The hs_end that makes lc = V_BACK+1 opens row 0 and the state goes to HBP.
  - HBP: count clocks from offset 0. When the s1 sample at offset H_BACK is reached, go to ACTIVE with x=0.
  - ACTIVE: for H_ACTIVE cycles, emit the s1 pixel with the current x/y. After the last pixel, either:
    - go to HBLANK if the row was below V_ACTIVE-1, or
    - finish the frame and go to WAIT_VS.
  - HBLANK: the next hs_end opens the next row and the state goes to HBP.
  - WAIT_VS: vs_end gives lc=0 and the state goes to VBLANK.
- **Error handling:**
  - hs_end in ACTIVE: pulse `line_err`, clear the frame-ok flag, abandon the row, and treat the event as the opening of the next row. If the abandoned row was the last row, finish the frame.
  - vs_end in VBLANK, HBP, ACTIVE or HBLANK: pulse `frame_err`. The frame is discarded: no `frame_done`, and `frame_sum` and `frame_cnt` are unchanged. Restart with lc=0 in VBLANK.
- **Priority.** When vs_end and hs_end fall in the same cycle, vs_end is processed and that hs_end is ignored.
- **Checksum.** The accumulator clears at `frame_start`; the cycle with `frame_start` itself loads the first pixel's value. Add {r,g,b} zero-extended to 32 bits, wrapping.

## Timing
- Latency is 2 clocks from pins to `pix_*`: pins at cycle t, s1 at t+1, outputs registered at t+2.
- `pix_valid` is high for exactly H_ACTIVE consecutive cycles per good row. `pix_x` runs 0..H_ACTIVE-1.
- `frame_start` is high only with `pix_valid` at x=0, y=0.
- The `frame_done` cycle:
  - falls one cycle after the last `pix_valid` of the frame;
  - updates `frame_sum`, `frame_ok` and `frame_cnt` (+1) on the same edge;
  - holds those values until the next `frame_done`.
- `line_err` and `frame_err` are single-cycle pulses, 2 clocks after the offending sync edge at the pins.
- Reset asserted mid-frame forces all outputs to 0 immediately (asynchronously). Capture restarts only after a fresh vs_end.

## Test plan
Benches use small parameters unless stated: H_ACTIVE=8, V_ACTIVE=4, H_BACK=3, V_BACK=2, HS_POL=VS_POL=0.
- **Reset and idle.** Hold rst, then release it with syncs inactive and random RGB → all outputs 0, no `pix_valid` for 200 cycles.
- **Nominal frame.** Drive a counting pattern, pixel = 8·y+x → 32 `pix_valid` cycles with correct x/y; `frame_start` at the first pixel; `frame_done` with `frame_sum`=496, `frame_ok`=1, `frame_cnt`=1. A second frame gives `frame_cnt`=2.
- **Short line.** Assert hsync after 5 pixels of row 1 → `line_err` pulse; row 2 starts on that event; `frame_done` with `frame_ok`=0 and `frame_sum` equal to the sum of captured pixels.
- **Early vsync.** Give a vsync end during row 2 → `frame_err` pulse, no `frame_done`, `frame_cnt` unchanged; the following full frame is captured with `frame_ok`=1.
- **Reset mid-frame.** Assert rst during row 1 → outputs 0 at once; after release, nothing is captured until the next vsync end; then a clean frame with `frame_sum`=496.
- **Full-size, active-high syncs.** Use defaults with HS_POL=VS_POL=1, 1344×806 timing and constant pixel 16'h0001 → `frame_sum`=786432, `pix_x` max 1023, `pix_y` max 767.
